mseq_run_ctrl: RTL and testbench
================================

Name: mseq_run_ctrl

Overview:
- Configuration and run sequencer for a bank of MSEQ_NUM M-sequence (LFSR) generators.
- Holds per-channel seed (feedback polynomial) and initial-state registers written over a simple host strobe interface, and drives them onto flattened buses feeding the generator array.
- On a start command, loads the enabled channels one per cycle, enables them for a programmed number of chips, then signals completion.

Parameters:
- MSEQ_DATA_WIDTH, 16, width of each seed and initial value.
- MSEQ_NUM, 8, number of generator channels (2..16).
- ADDR_WIDTH, 3, channel address width; must satisfy 2**ADDR_WIDTH >= MSEQ_NUM.
- CNT_WIDTH, 16, width of run length and chip counter.

Ports:
- MSEQ_clk  in  1  single clock, rising edge.
- MSEQ_rst_n  in  1  asynchronous active-low reset.
- cfg_wr_en  in  1  config write strobe, one cycle per write.
- cfg_addr  in  ADDR_WIDTH  target channel index.
- cfg_seed  in  MSEQ_DATA_WIDTH  seed to store.
- cfg_init  in  MSEQ_DATA_WIDTH  initial value to store.
- start  in  1  run request pulse.
- abort  in  1  terminate the current run.
- ch_mask  in  MSEQ_NUM  channel enable mask, sampled on accepted start.
- run_len  in  CNT_WIDTH  chips to run, sampled on accepted start.
- MSEQ_seed_bus  out  MSEQ_NUM*MSEQ_DATA_WIDTH  stored seeds; channel i at bits [i*W +: W].
- MSEQ_init_bus  out  MSEQ_NUM*MSEQ_DATA_WIDTH  stored initial values, same packing.
- MSEQ_load  out  MSEQ_NUM  per-channel load pulse.
- MSEQ_en  out  MSEQ_NUM  per-channel shift enable.
- busy  out  1  high in LOAD and RUN.
- done  out  1  one-cycle completion pulse.
- aborted  out  1  one-cycle abort acknowledge.
- cfg_err  out  1  one-cycle pulse on a rejected write or start.
- chip_cnt  out  CNT_WIDTH  RUN cycles elapsed in the current or last run.

Behaviour:
- Reset: all seed/init bank registers, the sampled mask and run length, chip_cnt, and all outputs are 0. State is IDLE.
- All outputs are registered.
- Config write (cfg_wr_en=1):
  - Accepted only in IDLE with cfg_addr < MSEQ_NUM.
  - The bank entry updates on the next edge and is visible on the buses one cycle after the strobe.
  - Otherwise (busy, DONE, or out-of-range address) the bank is unchanged and cfg_err pulses the next cycle.
- Start in IDLE with ch_mask != 0:
  - Accepted: ch_mask and run_len are latched, chip_cnt clears to 0, and the state goes to LOAD.
  - If ch_mask == 0: ignored, cfg_err pulses.
  - Start in any other state: ignored silently.
  - Simultaneous cfg_wr_en and start in IDLE: the write is applied first, and the load sees the new value.
- States:
  - IDLE: waits for an accepted start.
  - LOAD: an index counter k runs 0..MSEQ_NUM-1, one cycle each; MSEQ_load[k] = mask[k]; always lasts MSEQ_NUM cycles.
  - RUN: MSEQ_en = mask for exactly run_len cycles; chip_cnt increments each RUN cycle. run_len == 0 skips RUN.
  - DONE: one cycle; done=1, busy=0, MSEQ_en=0; then IDLE.
- Timing for a start sampled at edge T (inputs high in cycle T):
  - busy rises at T+1.
  - MSEQ_load[i] pulses at T+1+i.
  - MSEQ_en is high for cycles T+1+N .. T+N+run_len, where N = MSEQ_NUM.
  - done pulses at T+1+N+run_len.
- Abort:
  - Abort in LOAD or RUN:
    - Next cycle: state is IDLE, MSEQ_load/MSEQ_en/busy are 0, and aborted pulses.
    - done is not asserted, and chip_cnt holds its value.
  - Abort in IDLE or DONE: ignored.
  - Abort has priority over the LOAD→RUN and RUN→DONE transitions in the same cycle.
- chip_cnt saturates at 2**CNT_WIDTH-1; it cannot wrap, since it is bounded by run_len.
- Asynchronous reset mid-run: everything returns to reset values immediately, and no done is asserted.

Test Plan:
- Write ch3 seed=0xB400 init=0x0001; start with mask=0x08 and run_len=5 → MSEQ_seed_bus[63:48]=0xB400; MSEQ_load=0x08 only in the 4th LOAD cycle; MSEQ_en=0x08 for 5 cycles; done 14 cycles after start (N=8); chip_cnt=5.
- Start with mask=0xFF and run_len=0 → MSEQ_load walks 0x01..0x80 on consecutive cycles; MSEQ_en never set; done at start+9.
- cfg_wr_en with cfg_addr=2 during RUN, and a write with cfg_addr=... (out of range only if MSEQ_NUM<2**ADDR_WIDTH; use MSEQ_NUM=6, addr=7) → cfg_err pulses each time; bank contents unchanged.
- Start with mask=0x00 → cfg_err pulses; busy stays 0. A second start while busy is ignored, with no timing change.
- Start with run_len=100 and abort in RUN cycle 10 → next cycle aborted=1, busy=0, MSEQ_en=0, chip_cnt=10; no done.
- Assert MSEQ_rst_n low during LOAD → all outputs and the banks are 0 asynchronously; after release, state is IDLE and a new start runs normally.

Source files
------------

// File: rtl/mseq_run_ctrl.sv
// mseq_run_ctrl
// Configuration store and run sequencer for a bank of MSEQ_NUM M-sequence
// (LFSR) generators. A host writes a per-channel seed (feedback polynomial)
// and initial state, which are driven continuously onto flattened buses.
// A start command loads the enabled channels one per cycle and then enables
// them for a programmed number of chips before signalling completion.
//
// Ports:
//   MSEQ_clk, MSEQ_rst_n     clock (rising edge), async active-low reset
//   cfg_wr_en/addr/seed/init config write strobe, channel, seed, initial value
//   start, abort             run request pulse, run termination
//   ch_mask, run_len         channel enable mask and chip count (sampled on start)
//   MSEQ_seed_bus/init_bus   stored seeds / initial values, channel i at [i*W +: W]
//   MSEQ_load, MSEQ_en       per-channel load pulse and shift enable
//   busy, done, aborted      run status; done/aborted are one-cycle pulses
//   cfg_err                  one-cycle pulse for a rejected write or start
//   chip_cnt                 RUN cycles elapsed in the current or last run
//
// Protocol: cfg_wr_en, start and abort are single-cycle strobes with no
// back-pressure. A strobe is either acted on at the sampling edge or dropped;
// a dropped write or zero-mask start is reported by cfg_err one cycle later,
// a start while not idle is dropped silently. Every output is registered, so
// the effect of a strobe is visible no earlier than the following cycle.
module mseq_run_ctrl #(
  parameter int MSEQ_DATA_WIDTH = 16,
  parameter int MSEQ_NUM        = 8,
  parameter int ADDR_WIDTH      = 3,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                                MSEQ_clk,
  input  logic                                MSEQ_rst_n,
  input  logic                                cfg_wr_en,
  input  logic [ADDR_WIDTH-1:0]               cfg_addr,
  input  logic [MSEQ_DATA_WIDTH-1:0]          cfg_seed,
  input  logic [MSEQ_DATA_WIDTH-1:0]          cfg_init,
  input  logic                                start,
  input  logic                                abort,
  input  logic [MSEQ_NUM-1:0]                 ch_mask,
  input  logic [CNT_WIDTH-1:0]                run_len,
  output logic [MSEQ_NUM*MSEQ_DATA_WIDTH-1:0] MSEQ_seed_bus,
  output logic [MSEQ_NUM*MSEQ_DATA_WIDTH-1:0] MSEQ_init_bus,
  output logic [MSEQ_NUM-1:0]                 MSEQ_load,
  output logic [MSEQ_NUM-1:0]                 MSEQ_en,
  output logic                                busy,
  output logic                                done,
  output logic                                aborted,
  output logic                                cfg_err,
  output logic [CNT_WIDTH-1:0]                chip_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] K_LAST   = ADDR_WIDTH'(MSEQ_NUM - 1);
  localparam logic [CNT_WIDTH-1:0]  CHIP_MAX = '1;

  state_t                     r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0]      r_k, w_k_nxt;
  logic [CNT_WIDTH-1:0]       r_chip, w_chip_nxt;
  logic [MSEQ_NUM-1:0]        r_mask, w_mask_nxt;
  logic [CNT_WIDTH-1:0]       r_len;
  logic [MSEQ_DATA_WIDTH-1:0] r_seed [MSEQ_NUM];
  logic [MSEQ_DATA_WIDTH-1:0] r_init [MSEQ_NUM];

  logic                r_busy, r_done, r_aborted, r_cfg_err;
  logic [MSEQ_NUM-1:0] r_load, r_en;
  logic [MSEQ_NUM-1:0] w_load_nxt, w_en_nxt;

  logic w_idle, w_addr_ok, w_wr_ok, w_wr_bad;
  logic w_start_ok, w_start_bad, w_abort_ok;

  always_comb begin
    w_idle      = (r_state == S_IDLE);
    w_addr_ok   = (32'(cfg_addr) < 32'(MSEQ_NUM));
    w_wr_ok     = cfg_wr_en & w_idle & w_addr_ok;
    w_wr_bad    = cfg_wr_en & ~w_wr_ok;
    w_start_ok  = start & w_idle & (|ch_mask);
    w_start_bad = start & w_idle & ~(|ch_mask);
    w_abort_ok  = abort & ((r_state == S_LOAD) | (r_state == S_RUN));
  end

  // r_chip counts the RUN cycle currently being output (1..run_len), so it
  // advances together with the state that produces MSEQ_en and simply holds
  // when a run is aborted.
  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_chip_nxt  = r_chip;
    unique case (r_state)
      S_IDLE: begin
        if (w_start_ok) begin
          w_state_nxt = S_LOAD;
          w_k_nxt     = '0;
          w_chip_nxt  = '0;
        end
      end
      S_LOAD: begin
        if (w_abort_ok) begin
          w_state_nxt = S_IDLE;
        end else if (r_k == K_LAST) begin
          if (r_len == '0) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_RUN;
            w_chip_nxt  = CNT_WIDTH'(1);
          end
        end else begin
          w_k_nxt = r_k + 1'b1;
        end
      end
      S_RUN: begin
        if (w_abort_ok) begin
          w_state_nxt = S_IDLE;
        end else if (r_chip == r_len) begin
          w_state_nxt = S_DONE;
        end else if (r_chip != CHIP_MAX) begin
          w_chip_nxt = r_chip + 1'b1;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are computed from the next state so that they appear in the
  // same cycle as the state they describe.
  always_comb begin
    w_mask_nxt = w_start_ok ? ch_mask : r_mask;
    w_load_nxt = '0;
    w_en_nxt   = '0;
    if (w_state_nxt == S_LOAD) begin
      w_load_nxt = w_mask_nxt & (MSEQ_NUM'(1) << w_k_nxt);
    end
    if (w_state_nxt == S_RUN) begin
      w_en_nxt = r_mask;
    end
  end

  always_ff @(posedge MSEQ_clk or negedge MSEQ_rst_n) begin
    if (!MSEQ_rst_n) begin
      r_state   <= S_IDLE;
      r_k       <= '0;
      r_chip    <= '0;
      r_mask    <= '0;
      r_len     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      r_cfg_err <= 1'b0;
      r_load    <= '0;
      r_en      <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_k       <= w_k_nxt;
      r_chip    <= w_chip_nxt;
      r_mask    <= w_mask_nxt;
      if (w_start_ok) begin
        r_len <= run_len;
      end
      r_busy    <= (w_state_nxt == S_LOAD) | (w_state_nxt == S_RUN);
      r_done    <= (w_state_nxt == S_DONE);
      r_aborted <= w_abort_ok;
      r_cfg_err <= w_wr_bad | w_start_bad;
      r_load    <= w_load_nxt;
      r_en      <= w_en_nxt;
    end
  end

  // A write issued together with a start lands at the same edge the run
  // begins, so the later load already sees the new bank contents.
  always_ff @(posedge MSEQ_clk or negedge MSEQ_rst_n) begin
    if (!MSEQ_rst_n) begin
      for (int i = 0; i < MSEQ_NUM; i++) begin
        r_seed[i] <= '0;
        r_init[i] <= '0;
      end
    end else begin
      for (int i = 0; i < MSEQ_NUM; i++) begin
        if (w_wr_ok && (cfg_addr == ADDR_WIDTH'(i))) begin
          r_seed[i] <= cfg_seed;
          r_init[i] <= cfg_init;
        end
      end
    end
  end

  for (genvar g = 0; g < MSEQ_NUM; g++) begin : g_bus
    assign MSEQ_seed_bus[g*MSEQ_DATA_WIDTH +: MSEQ_DATA_WIDTH] = r_seed[g];
    assign MSEQ_init_bus[g*MSEQ_DATA_WIDTH +: MSEQ_DATA_WIDTH] = r_init[g];
  end

  assign MSEQ_load = r_load;
  assign MSEQ_en   = r_en;
  assign busy      = r_busy;
  assign done      = r_done;
  assign aborted   = r_aborted;
  assign cfg_err   = r_cfg_err;
  assign chip_cnt  = r_chip;

endmodule

// File: tb/tb_mseq_run_ctrl.sv
// tb_mseq_run_ctrl
// Bench for mseq_run_ctrl with six channels, so that channel addresses 6 and
// 7 are out of range. The driver computes each run's cycle-by-cycle
// behaviour from the timing rules (load pulse i at start+1+i, enables for
// run_len cycles after the N load cycles, done or aborted at the end) and
// queues the expected output events; a monitor pops and compares them
// whenever the DUT shows any activity.
module tb_mseq_run_ctrl;

  localparam int DW = 16;
  localparam int N  = 6;
  localparam int AW = 3;
  localparam int CW = 16;
  localparam int RW = 32 + 4 + 2*N + CW;
  localparam int BW = 32 + 2*N*DW;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          cfg_wr_en = 1'b0;
  logic [AW-1:0] cfg_addr  = '0;
  logic [DW-1:0] cfg_seed  = '0;
  logic [DW-1:0] cfg_init  = '0;
  logic          start     = 1'b0;
  logic          abort     = 1'b0;
  logic [N-1:0]  ch_mask   = '0;
  logic [CW-1:0] run_len   = '0;

  logic [N*DW-1:0] MSEQ_seed_bus, MSEQ_init_bus;
  logic [N-1:0]    MSEQ_load, MSEQ_en;
  logic            busy, done, aborted, cfg_err;
  logic [CW-1:0]   chip_cnt;

  mseq_run_ctrl #(
    .MSEQ_DATA_WIDTH(DW),
    .MSEQ_NUM       (N),
    .ADDR_WIDTH     (AW),
    .CNT_WIDTH      (CW)
  ) dut (
    .MSEQ_clk     (clk),
    .MSEQ_rst_n   (rst_n),
    .cfg_wr_en    (cfg_wr_en),
    .cfg_addr     (cfg_addr),
    .cfg_seed     (cfg_seed),
    .cfg_init     (cfg_init),
    .start        (start),
    .abort        (abort),
    .ch_mask      (ch_mask),
    .run_len      (run_len),
    .MSEQ_seed_bus(MSEQ_seed_bus),
    .MSEQ_init_bus(MSEQ_init_bus),
    .MSEQ_load    (MSEQ_load),
    .MSEQ_en      (MSEQ_en),
    .busy         (busy),
    .done         (done),
    .aborted      (aborted),
    .cfg_err      (cfg_err),
    .chip_cnt     (chip_cnt)
  );

  // ---------------- scoreboard state ----------------
  logic [RW-1:0] exp_q[$];
  logic [BW-1:0] bus_q[$];
  logic [DW-1:0] seed_m[N];
  logic [DW-1:0] init_m[N];
  logic [CW-1:0] last_chip;
  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [RW-1:0] pack(int c, logic b, logic d, logic ab, logic ce,
                                         logic [N-1:0] ld, logic [N-1:0] en, logic [CW-1:0] cc);
    return {32'(c), b, d, ab, ce, ld, en, cc};
  endfunction

  // ---------------- monitor ----------------
  initial begin : monitor
    logic [RW-1:0] act;
    logic [RW-1:0] exp;
    logic [BW-1:0] bexp;
    logic          evt;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        n_cmp++;
        if ({busy, done, aborted, cfg_err, MSEQ_load, MSEQ_en, chip_cnt,
             MSEQ_seed_bus, MSEQ_init_bus} !== '0) begin
          n_err++;
          $display("FAIL reset_outputs cyc=%0d got busy=%b done=%b ab=%b err=%b load=%h en=%h chip=%0d seed=%h init=%h required all zero",
                   cyc, busy, done, aborted, cfg_err, MSEQ_load, MSEQ_en, chip_cnt, MSEQ_seed_bus, MSEQ_init_bus);
        end
      end else begin
        act = pack(cyc, busy, done, aborted, cfg_err, MSEQ_load, MSEQ_en, chip_cnt);
        evt = busy | done | aborted | cfg_err | (|MSEQ_load) | (|MSEQ_en);
        if (evt) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_output got=%h required=no activity", act);
          end else begin
            exp = exp_q.pop_front();
            if (exp !== act) begin
              n_err++;
              $display("FAIL output_event got=%h required=%h", act, exp);
            end
          end
        end else if (exp_q.size() > 0 && exp_q[0][RW-1 -: 32] <= 32'(cyc)) begin
          n_cmp++;
          n_err++;
          exp = exp_q.pop_front();
          $display("FAIL missing_output cyc=%0d got=%h required=%h", cyc, act, exp);
        end
        while (bus_q.size() > 0 && bus_q[0][BW-1 -: 32] <= 32'(cyc)) begin
          bexp = bus_q.pop_front();
          n_cmp++;
          if (bexp[BW-33:0] !== {MSEQ_init_bus, MSEQ_seed_bus}) begin
            n_err++;
            $display("FAIL bank_buses cyc=%0d got init=%h seed=%h required init=%h seed=%h",
                     cyc, MSEQ_init_bus, MSEQ_seed_bus, bexp[BW-33 -: N*DW], bexp[N*DW-1:0]);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_banks();
    logic [N*DW-1:0] s;
    logic [N*DW-1:0] iv;
    for (int k = 0; k < N; k++) begin
      s[k*DW +: DW]  = seed_m[k];
      iv[k*DW +: DW] = init_m[k];
    end
    bus_q.push_back({32'(cyc), iv, s});
  endtask

  // Single write issued while idle.
  task automatic cfg_write(logic [AW-1:0] a, logic [DW-1:0] sd, logic [DW-1:0] iv);
    cfg_wr_en = 1'b1;
    cfg_addr  = a;
    cfg_seed  = sd;
    cfg_init  = iv;
    if (int'(a) < N) begin
      seed_m[a] = sd;
      init_m[a] = iv;
    end else begin
      exp_q.push_back(pack(cyc + 1, 1'b0, 1'b0, 1'b0, 1'b1, '0, '0, last_chip));
    end
    step();
    cfg_wr_en = 1'b0;
  endtask

  // Start at relative cycle 0 with (mask, len). Optional disturbances at
  // relative cycles: abort at a_in, write to waddr at w, second start at s_in
  // (-1 = none).
  task automatic run_op(logic [N-1:0] mask, int len, int a_in, int w,
                        logic [AW-1:0] waddr, int s_in);
    logic         bz[128];
    logic         dn[128];
    logic         ab[128];
    logic         ce[128];
    logic [N-1:0] ld[128];
    logic [N-1:0] en[128];
    logic [CW-1:0] cc[128];
    logic [CW-1:0] fin_chip;
    logic [DW-1:0] sd;
    logic [DW-1:0] iv;
    int  t0, fin, act_end, len_c, a, s;
    bit  was_aborted, wr_acc;
    t0 = cyc;
    a  = a_in;
    s  = s_in;
    was_aborted = 1'b0;
    act_end = 0;
    if (mask == '0) begin
      fin      = 0;
      a        = -1;
      s        = -1;
      fin_chip = last_chip;
    end else if (a >= 1 && a <= N + len) begin
      was_aborted = 1'b1;
      act_end  = a;
      fin      = a;
      fin_chip = (a <= N) ? '0 : CW'(a - N);
    end else begin
      act_end  = N + len;
      fin      = N + 1 + len;
      fin_chip = CW'(len);
    end
    if (s > fin) s = -1;
    len_c = fin + 2;
    if (w + 2 > len_c) len_c = w + 2;
    if (a + 1 > len_c) len_c = a + 1;
    for (int c = 0; c < 128; c++) begin
      bz[c] = 1'b0; dn[c] = 1'b0; ab[c] = 1'b0; ce[c] = 1'b0;
      ld[c] = '0;   en[c] = '0;   cc[c] = fin_chip;
    end
    if (mask == '0) begin
      ce[1] = 1'b1;
    end else begin
      for (int c = 1; c <= act_end; c++) begin
        bz[c] = 1'b1;
        if (c <= N) begin
          ld[c] = mask & (N'(1) << (c - 1));
          cc[c] = '0;
        end else begin
          en[c] = mask;
          cc[c] = CW'(c - N);
        end
      end
      if (was_aborted) ab[a + 1] = 1'b1;
      else             dn[fin]   = 1'b1;
    end
    wr_acc = 1'b0;
    if (w >= 0) begin
      if ((w >= 1 && w <= fin) || int'(waddr) >= N) ce[w + 1] = 1'b1;
      else wr_acc = 1'b1;
    end
    for (int c = 1; c < len_c; c++) begin
      if (bz[c] | dn[c] | ab[c] | ce[c] | (|ld[c]) | (|en[c]))
        exp_q.push_back(pack(t0 + c, bz[c], dn[c], ab[c], ce[c], ld[c], en[c], cc[c]));
    end
    for (int c = 0; c < len_c; c++) begin
      start     = (c == 0) || (c == s);
      ch_mask   = (c == 0) ? mask : N'($urandom);
      run_len   = (c == 0) ? CW'(len) : CW'($urandom_range(0, 50));
      abort     = (c == a);
      cfg_wr_en = (c == w);
      if (c == w) begin
        sd = DW'($urandom);
        iv = DW'($urandom);
        cfg_addr = waddr;
        cfg_seed = sd;
        cfg_init = iv;
        if (wr_acc) begin
          seed_m[waddr] = sd;
          init_m[waddr] = iv;
        end
      end
      step();
    end
    start = 1'b0; abort = 1'b0; cfg_wr_en = 1'b0; ch_mask = '0; run_len = '0;
    last_chip = fin_chip;
  endtask

  // Reset pulled low asynchronously in the third LOAD cycle.
  task automatic reset_mid_load();
    int t0;
    t0 = cyc;
    start   = 1'b1;
    ch_mask = '1;
    run_len = CW'(10);
    exp_q.push_back(pack(t0 + 1, 1'b1, 1'b0, 1'b0, 1'b0, N'(1), '0, '0));
    exp_q.push_back(pack(t0 + 2, 1'b1, 1'b0, 1'b0, 1'b0, N'(2), '0, '0));
    step();
    start = 1'b0; ch_mask = '0; run_len = '0;
    step();
    step();
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    for (int k = 0; k < N; k++) begin
      seed_m[k] = '0;
      init_m[k] = '0;
    end
    last_chip = '0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  // ---------------- stimulus ----------------
  initial begin : driver
    logic [N-1:0] r_mask_v;
    int r_len_v, r_a, r_w, r_s, r_nw;
    for (int k = 0; k < N; k++) begin
      seed_m[k] = '0;
      init_m[k] = '0;
    end
    last_chip = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    expect_banks();

    // ch3 programmed, single-channel run of 5 chips
    cfg_write(3'd3, 16'hB400, 16'h0001);
    expect_banks();
    run_op(6'h08, 5, -1, -1, 3'd0, -1);
    // all channels, zero-length run: load walk only
    run_op(6'h3F, 0, -1, -1, 3'd0, -1);
    // write during RUN rejected, out-of-range write rejected
    run_op(6'h05, 8, -1, N + 3, 3'd2, -1);
    expect_banks();
    cfg_write(3'd7, 16'h1234, 16'h5678);
    expect_banks();
    // zero mask start, then a second start while busy
    run_op(6'h00, 5, -1, -1, 3'd0, -1);
    run_op(6'h21, 4, -1, -1, 3'd0, 3);
    // abort in RUN cycle 10
    run_op(6'h3F, 100, N + 10, -1, 3'd0, -1);
    // write in DONE rejected
    run_op(6'h02, 2, -1, N + 3, 3'd4, -1);
    expect_banks();
    // write together with start is applied
    run_op(6'h10, 3, -1, 0, 3'd1, -1);
    expect_banks();
    // abort in LOAD, abort in DONE ignored
    run_op(6'h3F, 5, 3, -1, 3'd0, -1);
    run_op(6'h01, 2, N + 3, -1, 3'd0, -1);
    // reset during LOAD, then a normal run
    reset_mid_load();
    expect_banks();
    run_op(6'h0C, 4, -1, -1, 3'd0, -1);

    for (int it = 0; it < 30; it++) begin
      r_nw = $urandom_range(0, 2);
      for (int j = 0; j < r_nw; j++)
        cfg_write(AW'($urandom_range(0, 7)), DW'($urandom), DW'($urandom));
      expect_banks();
      r_mask_v = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
      r_len_v  = $urandom_range(0, 20);
      r_a = ($urandom_range(0, 2) == 0) ? $urandom_range(1, N + r_len_v + 2) : -1;
      r_w = ($urandom_range(0, 2) == 0) ? $urandom_range(0, N + r_len_v + 3) : -1;
      r_s = ($urandom_range(0, 3) == 0) ? $urandom_range(1, N + r_len_v + 1) : -1;
      run_op(r_mask_v, r_len_v, r_a, r_w, AW'($urandom_range(0, 7)), r_s);
      expect_banks();
    end

    repeat (5) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog time limit reached before end of stimulus");
    $fatal(1, "watchdog");
  end

endmodule
